fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the pipelined MIPS CPU.
- Owns the PC register and drives the word address into the combinational instruction memory (read index = addr>>2).
- Captures the returned word into the IF/ID pipeline register.
- Handles load-use stalls, ID-stage branch/jump redirects with flush, and an out-of-range halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- IMEM_DEPTH, 128, instruction memory depth in words. The fetch window is [0, IMEM_DEPTH*4).
- NOP_WORD, 32'h0000_0000, bubble encoding written into IF/ID.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  squash the IF/ID contents (bubble) at this edge.
- branch_taken  in  1  branch resolved taken in ID.
- branch_target  in  32  byte address of the branch destination.
- jump  in  1  j resolved in ID.
- jump_target  in  32  byte address, already formed as {pc+4[31:28], idx, 2'b00}.
- imem_addr  out  32  current PC to instruction memory.
- imem_rdata  in  32  instruction word, combinational from imem_addr.
- if_id_instr  out  32  registered instruction.
- if_id_pc_plus4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- halted  out  1  fetch has stopped.

Behaviour:
- Reset (synchronous, active-high): sets PC=RESET_PC, if_id_instr=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0, halted=0, FSM=RUN. Reset overrides every other input in the same cycle.
- imem_addr = PC (combinational). Instruction memory has zero latency, so the IF/ID capture happens at the same edge the PC advances.
- next_pc, in priority order:
  - jump → jump_target
  - else branch_taken → branch_target
  - else PC+4 (32-bit wrap)
- Per-edge update in RUN, in priority order:
  1. stall=1: PC and IF/ID hold. branch_taken, jump and flush are ignored; the hazard unit re-presents them after the stall.
  2. flush=1: PC←next_pc; IF/ID←{NOP_WORD, 0, valid=0}.
  3. Otherwise: PC←next_pc; if_id_instr←imem_rdata, if_id_pc_plus4←PC+4, if_id_valid←1.
- Redirects (jump or branch_taken) without flush are legal. The wrong-path instruction is latched valid, and its squashing is the control unit's responsibility.
- Halt FSM:
  - RUN→HALT when, at a non-stalled edge, the selected next_pc ≥ IMEM_DEPTH*4 or next_pc[1:0]≠0. The fetched instruction at that edge is still captured normally.
  - HALT: PC frozen, halted=1, IF/ID loads a bubble every edge, and all redirects are ignored. Only reset exits HALT.
- Misaligned redirect targets trigger HALT; they are never truncated.
- PC+4 wraps from 32'hFFFF_FFFC to 0 arithmetically, but any such value is already out of range and halts first.
- Simultaneous jump and branch_taken: jump wins.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds three 32-bit output counters:
  - perf_fetched: edges with if_id_valid loaded 1.
  - perf_stalled: edges with stall=1 in RUN.
  - perf_flushed: edges taking the flush path.
- Counters clear on reset and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds: WORD_W=32, NOP_WORD, RESET_PC, the IMEM_DEPTH default, and the FSM state typedef fetch_state_t {RUN, HALT}.
- One natural sub-module, if_id_reg: the IF/ID register with hold (stall) and bubble (flush/halt) controls. It is reusable as the template for ID/EX.
- The PC, next-PC mux and FSM stay in fetch_stage.

Test Plan:
- Reset then 4 free-running edges with a memory model holding 20080020, 20090037:
  - imem_addr steps 0,4,8,C.
  - After edge 1: if_id_instr=20080020, pc_plus4=4, valid=1.
- stall=1 for 2 edges at PC=0x20: PC stays 0x20 and IF/ID is unchanged. A branch_taken=1 (target 0x48) presented during the stall is ignored.
- beq taken at PC=0x24, branch_taken=1, target 0x48, flush=1 → next PC=0x48 and IF/ID is a bubble (valid=0, instr=0). The following edge latches the word at 0x48.
- jump=1 (target 0x38) together with branch_taken=1 (target 0x7C) → PC=0x38.
- Branch target 0x200 (IMEM_DEPTH=128) → halted=1 next cycle. Further jump to 0x0 has no effect, and valid stays 0 until reset returns PC to 0.
- reset asserted mid-stream at PC=0x40 with stall=1 → after the edge PC=0, valid=0, halted=0. With FETCH_PERF_CNT_EN defined, all counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, reset/bubble encodings, fetch FSM states.
// Also holds a saturating-increment helper used by the optional perf counters.
package cpu_pkg;
  localparam int                WORD_W     = 32;
  localparam logic [WORD_W-1:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000;
  localparam int                IMEM_DEPTH = 128;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (v == {WORD_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// Pipeline register (instruction, PC+4, valid) with hold and bubble controls.
// Priority: reset > hold > bubble > load. Intended as the template for ID/EX.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] BUBBLE_WORD = NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc_plus4_in,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc_plus4_out,
  output logic              valid_out
);
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_plus4_q, pc_plus4_d;
  logic              valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (!hold) begin
      if (bubble) begin
        instr_d    = BUBBLE_WORD;
        pc_plus4_d = '0;
        valid_d    = 1'b0;
      end else begin
        instr_d    = instr_in;
        pc_plus4_d = pc_plus4_in;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= BUBBLE_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC select, halt FSM, and IF/ID capture.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter int          IMEM_DEPTH = cpu_pkg::IMEM_DEPTH,
  parameter logic [31:0] NOP_WORD   = cpu_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled,
  output logic [31:0] perf_flushed,
`endif
  output logic        halted
);
  import cpu_pkg::WORD_W;
  import cpu_pkg::fetch_state_t;
  import cpu_pkg::RUN;
  import cpu_pkg::HALT;

  localparam logic [WORD_W-1:0] FETCH_LIMIT = WORD_W'(IMEM_DEPTH * 4);

  logic [WORD_W-1:0] pc_q, pc_d, pc_plus4, next_pc;
  fetch_state_t      state_q, state_d;
  logic              run, advance, bad_target;

  assign run      = (state_q == RUN);
  assign advance  = run && !stall;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    if (jump)              next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
    else                   next_pc = pc_plus4;
  end

  // Misaligned targets halt rather than being truncated to a word boundary.
  assign bad_target = (next_pc >= FETCH_LIMIT) || (next_pc[1:0] != 2'b00);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (advance) begin
      pc_d = next_pc;
      if (bad_target) state_d = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Stall only holds in RUN; once halted the register drains to bubbles.
  if_id_reg #(.BUBBLE_WORD(NOP_WORD)) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .hold         (run && stall),
    .bubble       (!run || flush),
    .instr_in     (imem_rdata),
    .pc_plus4_in  (pc_plus4),
    .instr_out    (if_id_instr),
    .pc_plus4_out (if_id_pc_plus4),
    .valid_out    (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d, stalled_q, stalled_d, flushed_q, flushed_d;

  always_comb begin
    fetched_d = fetched_q;
    stalled_d = stalled_q;
    flushed_d = flushed_q;
    if (run && stall)                  stalled_d = cpu_pkg::sat_inc(stalled_q);
    if (advance && flush)              flushed_d = cpu_pkg::sat_inc(flushed_q);
    if (advance && !flush)             fetched_d = cpu_pkg::sat_inc(fetched_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stalled_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalled_q <= stalled_d;
      flushed_q <= flushed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalled = stalled_q;
  assign perf_flushed = flushed_q;
`endif
endmodule
